// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues burst reads from PC, buffers returned words with their
// addresses in a FIFO, and serves decode over valid/ready. Optional perf counters: FETCH_PERF_EN.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 32'h8002_0000,
  parameter int unsigned           BURST_WORDS = 4,
  parameter int unsigned           FIFO_DEPTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [1:0]            mem_access_size,
  output logic                  mem_rw,
  output logic                  mem_enable,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  input  logic                  redirect,
`ifdef FETCH_PERF_EN
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [31:0]           perf_insn_cnt,
  output logic [31:0]           perf_flush_cnt
`else
  input  logic [ADDR_WIDTH-1:0] redirect_pc
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(BURST_WORDS) + 1;

  localparam logic [1:0] ACCESS_SIZE = (BURST_WORDS == 16) ? 2'b11 :
                                       (BURST_WORDS == 8)  ? 2'b10 :
                                       (BURST_WORDS == 4)  ? 2'b01 : 2'b00;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(4 * BURST_WORDS);
  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES  = ADDR_WIDTH'(4);
  localparam logic [OCC_W-1:0]      DEPTH_V     = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0]      BURST_V     = OCC_W'(BURST_WORDS);
  localparam logic [CNT_W-1:0]      CNT_INIT    = CNT_W'(BURST_WORDS);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   tag_q, tag_d;

  logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]        occ_q;
  logic [OCC_W-1:0]        free_slots;
  logic                    push, pop;

  logic [DATA_WIDTH-1:0]   data_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   tag_mem  [FIFO_DEPTH];

  assign free_slots = DEPTH_V - occ_q;
  assign push       = (state_q == S_RECV) && !redirect;
  assign pop        = insn_valid && insn_ready && !redirect;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= START_ADDR;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    tag_d   = tag_q;
    case (state_q)
      S_IDLE: begin
        if (!mem_busy && (free_slots >= BURST_V) && !redirect)
          state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_RECV;
        cnt_d   = CNT_INIT;
        pc_d    = pc_q + BURST_BYTES;
        tag_d   = pc_q;
      end
      S_RECV, S_DRAIN: begin
        tag_d = tag_q + WORD_BYTES;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A redirect mid-burst still consumes this cycle's word, so DRAIN
    // covers only the words that have yet to arrive.
    if (redirect) begin
      pc_d = redirect_pc & ~ADDR_WIDTH'(3);
      if (state_q == S_REQ) begin
        state_d = S_DRAIN;
        cnt_d   = CNT_INIT;
      end else if ((state_q == S_RECV) && (cnt_q != CNT_ONE)) begin
        state_d = S_DRAIN;
      end
    end
  end

  always_comb begin
    mem_enable      = 1'b0;
    mem_rw          = 1'b1;
    mem_access_size = ACCESS_SIZE;
    mem_address     = pc_q;
    case (state_q)
      S_REQ:   mem_enable = 1'b1;
      default: mem_enable = 1'b0;
    endcase
    insn_valid = (occ_q != '0);
    insn       = insn_valid ? data_mem[rd_ptr_q] : '0;
    insn_pc    = insn_valid ? tag_mem[rd_ptr_q]  : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else if (redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)
        occ_q <= occ_q + OCC_W'(1);
      else if (!push && pop)
        occ_q <= occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_q] <= mem_data;
      tag_mem[wr_ptr_q]  <= tag_q;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_insn_cnt  <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pop)      perf_insn_cnt  <= perf_insn_cnt + 32'd1;
      if (redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
